sync_multi: RTL and testbench

SYNC_MULTI -- requirements
Module: sync_multi

---
 rtl/sync_multi.sv | 95 +++++++++
 tb/tb_sync_multi.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_multi.sv
// sync_multi: per-channel STAGES-deep synchronizer with one-cycle rise/fall pulses on filt_out.
// Define SYNC_MULTI_FILTER_EN to add the FILT_CYC stability filter; otherwise filt_out tracks sync_out.
module sync_multi #(
   parameter int               WIDTH    = 4,
   parameter int               STAGES   = 2,
   parameter logic [WIDTH-1:0] RST_VAL  = '0,
   parameter int               FILT_CYC = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out,
   output logic [WIDTH-1:0] filt_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("sync_multi: WIDTH must be 1..32");
   end
   if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("sync_multi: STAGES must be 2..4");
   end
   if (FILT_CYC < 1 || FILT_CYC > 255) begin : g_bad_filt_cyc
      $error("sync_multi: FILT_CYC must be 1..255");
   end

   logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] fall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) sync_q[i] <= RST_VAL;
      end else begin
         sync_q[0] <= async_in;
         for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_out = sync_q[STAGES-1];

`ifdef SYNC_MULTI_FILTER_EN
   localparam int            CW       = $clog2(FILT_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);

   logic [CW-1:0]    cnt [WIDTH];
   logic [WIDTH-1:0] filt_q;
   logic [WIDTH-1:0] load;

   // A channel commits only after sync_out has disagreed with filt_out for FILT_CYC edges in a row.
   always_comb begin
      load = '0;
      for (int i = 0; i < WIDTH; i++) begin
         load[i] = (sync_out[i] != filt_q[i]) && (cnt[i] == CNT_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         filt_q <= RST_VAL;
         rise_q <= '0;
         fall_q <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         filt_q <= (filt_q & ~load) | (sync_out & load);
         rise_q <= load & sync_out;
         fall_q <= load & ~sync_out;
         for (int i = 0; i < WIDTH; i++) begin
            if (sync_out[i] == filt_q[i] || load[i]) cnt[i] <= '0;
            else                                     cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   assign filt_out = filt_q;
`else
   // Pulses are registered alongside the last stage so they line up with the sync_out change.
   always_ff @(posedge clk) begin
      if (rst) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
         fall_q <= ~sync_q[STAGES-2] & sync_q[STAGES-1];
      end
   end

   assign filt_out = sync_out;
`endif

   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: tb/tb_sync_multi.sv
// Self-checking bench for sync_multi (WIDTH=4, STAGES=2, RST_VAL=0, FILT_CYC=4).
// Expectations follow SYNC_MULTI_FILTER_EN so the same bench covers both builds.
module tb_sync_multi;

`ifdef SYNC_MULTI_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif
   localparam int FC  = 4;
   localparam int LAT = FILT ? 2 + FC : 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] async_in = '0;
   logic [3:0] sync_out, filt_out, rise, fall;

   sync_multi #(.WIDTH(4), .STAGES(2), .RST_VAL(4'h0), .FILT_CYC(FC)) dut (
      .clk(clk), .rst(rst), .async_in(async_in),
      .sync_out(sync_out), .filt_out(filt_out), .rise(rise), .fall(fall)
   );

   always #5 clk = ~clk;

   logic [15:0] exp_q[$];
   logic [15:0] exp_v;
   int n_checks = 0;
   int n_pass   = 0;

   // behavioural reference: two sync stages, filtered level, per-channel disagreement run length
   logic [3:0] m_s1 = '0, m_s2 = '0, m_filt = '0;
   int         m_run [4] = '{0, 0, 0, 0};

   // drive one clock: compute expected outputs after the edge, push them, then advance
   task automatic cyc(input logic [3:0] a, input logic r);
      logic [3:0] nf, rs, fl;
      async_in = a;
      rst      = r;
      rs = '0;
      fl = '0;
      if (r) begin
         m_s1 = '0; m_s2 = '0; m_filt = '0;
         for (int c = 0; c < 4; c++) m_run[c] = 0;
      end else begin
         nf = m_filt;
         if (FILT) begin
            for (int c = 0; c < 4; c++) begin
               if (m_s2[c] !== m_filt[c]) begin
                  m_run[c] = m_run[c] + 1;
                  if (m_run[c] >= FC) begin
                     nf[c]    = m_s2[c];
                     m_run[c] = 0;
                  end
               end else begin
                  m_run[c] = 0;
               end
            end
         end else begin
            nf = m_s1;
         end
         rs     = nf & ~m_filt;
         fl     = ~nf & m_filt;
         m_filt = nf;
         m_s2   = m_s1;
         m_s1   = a;
      end
      exp_q.push_back({m_s2, m_filt, rs, fl});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(4'h0, 1'b0);
   endtask

   // scoreboard: every cycle's outputs against the reference
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         n_checks++;
         if ({sync_out, filt_out, rise, fall} !== exp_v)
            $display("FAIL scoreboard t=%0t got %h exp %h", $time, {sync_out, filt_out, rise, fall}, exp_v);
         else n_pass++;
         n_checks++;
         if ((rise & fall) !== 4'h0) $display("FAIL rise_and_fall got %b exp 0000", rise & fall);
         else n_pass++;
      end
   end

   task automatic test_reset();
      cyc(4'hF, 1'b1);
      cyc(4'hF, 1'b1);
      n_checks++;
      if ({sync_out, filt_out, rise, fall} !== 16'h0)
         $display("FAIL reset_outputs got %h exp 0000", {sync_out, filt_out, rise, fall});
      else n_pass++;
      for (int e = 1; e <= LAT + 1; e++) begin
         cyc(4'hF, 1'b0);
         if (e == 2) begin
            n_checks++;
            if (sync_out !== 4'hF) $display("FAIL reset_sync_lat got %h exp f", sync_out);
            else n_pass++;
         end
         if (e == LAT - 1) begin
            n_checks++;
            if (filt_out !== 4'h0) $display("FAIL reset_filt_early got %h exp 0", filt_out);
            else n_pass++;
         end
         if (e == LAT) begin
            n_checks++;
            if ({filt_out, rise} !== 8'hFF) $display("FAIL reset_filt_rise got %h exp ff", {filt_out, rise});
            else n_pass++;
         end
         if (e == LAT + 1) begin
            n_checks++;
            if (rise !== 4'h0) $display("FAIL reset_rise_once got %h exp 0", rise);
            else n_pass++;
         end
      end
      idle(LAT + 4);
   endtask

   task automatic test_glitch();
      int hs = 0, hf = 0, nr = 0, nfl = 0;
      for (int e = 1; e <= 14; e++) begin
         cyc((e <= 3) ? 4'h1 : 4'h0, 1'b0);
         hs += int'(sync_out[0]); hf += int'(filt_out[0]);
         nr += int'(rise[0]);     nfl += int'(fall[0]);
      end
      n_checks++;
      if (hs !== 3) $display("FAIL glitch_sync_high got %0d exp 3", hs);
      else n_pass++;
      n_checks++;
      if ({hf, nr, nfl} !== {(FILT ? 0 : 3), (FILT ? 0 : 1), (FILT ? 0 : 1)})
         $display("FAIL glitch_filtered got %0d/%0d/%0d exp %0d/%0d/%0d", hf, nr, nfl,
                  FILT ? 0 : 3, FILT ? 0 : 1, FILT ? 0 : 1);
      else n_pass++;
   endtask

   task automatic test_pulse4();
      int first_f = -1, hf = 0, re = -1, fe = -1;
      for (int e = 1; e <= 16; e++) begin
         cyc((e <= 4) ? 4'h1 : 4'h0, 1'b0);
         if (filt_out[0]) begin
            hf++;
            if (first_f < 0) first_f = e;
         end
         if (rise[0]) re = e;
         if (fall[0]) fe = e;
      end
      n_checks++;
      if (first_f !== LAT || hf !== 4) $display("FAIL pulse4_filt got start %0d len %0d exp start %0d len 4", first_f, hf, LAT);
      else n_pass++;
      n_checks++;
      if (re !== LAT) $display("FAIL pulse4_rise got %0d exp %0d", re, LAT);
      else n_pass++;
      n_checks++;
      if (fe !== LAT + 4) $display("FAIL pulse4_fall got %0d exp %0d", fe, LAT + 4);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      repeat (LAT + 3) cyc(4'b0100, 1'b0);
      n_checks++;
      if (filt_out !== 4'b0100) $display("FAIL simul_setup got %b exp 0100", filt_out);
      else n_pass++;
      for (int e = 1; e <= LAT + 3; e++) begin
         cyc(4'b0010, 1'b0);
         if (e == LAT) begin
            n_checks++;
            if ({rise, fall} !== 8'b0010_0100) $display("FAIL simul_edges got %b_%b exp 0010_0100", rise, fall);
            else n_pass++;
         end
      end
      idle(LAT + 4);
   endtask

   task automatic test_reset_mid_filter();
      for (int e = 1; e <= 4; e++) cyc(4'h1, 1'b0);
      n_checks++;
      if (filt_out[0] !== (FILT ? 1'b0 : 1'b1)) $display("FAIL rstmid_pre got %b exp %b", filt_out[0], !FILT);
      else n_pass++;
      cyc(4'h1, 1'b1);
      n_checks++;
      if ({sync_out, filt_out, rise, fall} !== 16'h0)
         $display("FAIL rstmid_rst got %h exp 0000", {sync_out, filt_out, rise, fall});
      else n_pass++;
      for (int e = 1; e <= LAT + 2; e++) begin
         cyc(4'h1, 1'b0);
         if (e == LAT - 1) begin
            n_checks++;
            if (filt_out[0] !== 1'b0) $display("FAIL rstmid_early got %b exp 0", filt_out[0]);
            else n_pass++;
         end
         if (e == LAT) begin
            n_checks++;
            if ({filt_out[0], rise[0]} !== 2'b11) $display("FAIL rstmid_rise got %b exp 11", {filt_out[0], rise[0]});
            else n_pass++;
         end
      end
      idle(LAT + 4);
   endtask

   task automatic test_single_cycle();
      int hf = 0, re = -1, fe = -1;
      for (int e = 1; e <= 10; e++) begin
         cyc((e == 1) ? 4'h8 : 4'h0, 1'b0);
         hf += int'(filt_out[3]);
         if (rise[3]) re = e;
         if (fall[3]) fe = e;
      end
      n_checks++;
      if ({hf, re, fe} !== {(FILT ? 0 : 1), (FILT ? -1 : 2), (FILT ? -1 : 3)})
         $display("FAIL single_cycle got %0d/%0d/%0d exp %0d/%0d/%0d", hf, re, fe,
                  FILT ? 0 : 1, FILT ? -1 : 2, FILT ? -1 : 3);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [3:0] lvl = 4'h0;
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < 4; c++) begin
            if ($urandom_range(0, 5) == 0) lvl[c] = ~lvl[c];
         end
         cyc(lvl, ($urandom_range(0, 59) == 0));
      end
      idle(LAT + 4);
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_pulse4();
      test_simultaneous();
      test_reset_mid_filter();
      test_single_cycle();
      test_back_to_back();
      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() !== 0) $display("FAIL scoreboard_drain got %0d exp 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
